// File: rtl/btb_update_ctrl_pkg.sv
// btb_update_ctrl_pkg: shared BTB widths and the queued training entry type
package btb_update_ctrl_pkg;
   localparam int   INST_ADDR_W = 32;
   localparam logic TRUE        = 1'b1;
   localparam logic FALSE       = 1'b0;
   localparam int   BTB_IDX_W   = 8;
   localparam int   BTB_TAG_W   = 9;
   typedef logic [INST_ADDR_W-1:0] inst_addr_t;
   typedef struct packed {
      inst_addr_t pc;
      inst_addr_t target;
   } upd_t;
endpackage

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: synchronous FIFO of {pc, target} training entries with head view
module btb_upd_fifo
   import btb_update_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [INST_ADDR_W-1:0] push_pc,
   input  logic [INST_ADDR_W-1:0] push_target,
   output logic                   full,
   output logic                   empty,
   output logic [INST_ADDR_W-1:0] head_pc,
   output logic [INST_ADDR_W-1:0] head_target
);
   localparam int AW = $clog2(DEPTH);
   upd_t          mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          wr, rd;
   assign rd          = pop && !empty;
   // a full FIFO still takes a push when the head leaves in the same cycle
   assign wr          = push && (!full || rd);
   assign full        = cnt == (AW+1)'(DEPTH);
   assign empty       = cnt == '0;
   assign head_pc     = mem[rp].pc;
   assign head_target = mem[rp].target;
   always_ff @(posedge clk)
      if (wr) mem[wp] <= '{pc: push_pc, target: push_target};
   always_ff @(posedge clk)
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (wr) wp <= wp + AW'(1);
         if (rd) rp <= rp + AW'(1);
         cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
      end
endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: resolves EX branches against IF prediction, flushes on mispredict, queues BTB training
// Define BTB_UPD_STATS_EN to build the branch/mispredict/drop counters; otherwise the stat ports read 0.
module btb_update_ctrl
   import btb_update_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = BTB_IDX_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic                   ex_valid,
   input  logic [INST_ADDR_W-1:0] ex_pc,
   input  logic                   ex_taken,
   input  logic [INST_ADDR_W-1:0] ex_target,
   input  logic                   ex_pred_hit,
   input  logic [INST_ADDR_W-1:0] ex_pred_addr,
   input  logic [INST_ADDR_W-1:0] if_pc,
   output logic                   flush,
   output logic [INST_ADDR_W-1:0] redirect_pc,
   output logic                   btb_write,
   output logic [INST_ADDR_W-1:0] btb_pc,
   output logic [INST_ADDR_W-1:0] btb_addr,
   output logic                   upd_drop,
   output logic [31:0]            stat_branches,
   output logic [31:0]            stat_mispred,
   output logic [31:0]            stat_drops
);
   logic [INST_ADDR_W-1:0] pc4, pred_next, act_next, head_pc, head_target;
   logic                   acc, mis, train, full, empty, drop;
   assign pc4       = ex_pc + 32'd4;
   assign pred_next = ex_pred_hit ? ex_pred_addr : pc4;
   assign act_next  = ex_taken ? ex_target : pc4;
   assign acc       = ex_valid && rdy;
   assign mis       = acc && (pred_next != act_next);
   // not-taken outcomes never train since the BTB cannot invalidate
   assign train     = acc && ex_taken && (!ex_pred_hit || ex_pred_addr != ex_target);
   // avoid writing the BTB set IF is reading this cycle
   assign btb_write = !empty && rdy && (head_pc[IDX_W-1:0] != if_pc[IDX_W-1:0]);
   assign btb_pc    = empty ? '0 : head_pc;
   assign btb_addr  = empty ? '0 : head_target;
   assign drop      = train && full && !btb_write;
   btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (train),
      .pop        (btb_write),
      .push_pc    (ex_pc),
      .push_target(ex_target),
      .full       (full),
      .empty      (empty),
      .head_pc    (head_pc),
      .head_target(head_target)
   );
   always_ff @(posedge clk)
      if (rst) begin
         flush       <= FALSE;
         redirect_pc <= '0;
         upd_drop    <= FALSE;
      end else begin
         flush    <= mis;
         upd_drop <= drop;
         if (mis) redirect_pc <= act_next;
      end
`ifdef BTB_UPD_STATS_EN
   always_ff @(posedge clk)
      if (rst) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
         stat_drops    <= '0;
      end else begin
         stat_branches <= stat_branches + 32'(acc);
         stat_mispred  <= stat_mispred + 32'(mis);
         stat_drops    <= stat_drops + 32'(drop);
      end
`else
   assign stat_branches = '0;
   assign stat_mispred  = '0;
   assign stat_drops    = '0;
`endif
endmodule
